alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide over a shared accumulator.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  // Handshake: an operation transfers on a rising edge with in_valid & in_ready,
  // the result transfers on a rising edge with out_valid & out_ready; in_ready
  // depends only on state, never combinationally on out_ready.

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         op_code;

  logic               accept;
  logic               iter_op;
  logic               last_iter;

  assign accept    = in_valid && (state == IDLE);
  assign iter_op   = (alu_control >= OP_MUL) && (alu_control <= OP_REMU);
  assign last_iter = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = iter_op ? BUSY : DONE;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  // Single-cycle results computed straight from the offered operands.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, sc_ill;

  always_comb begin
    b_eff    = (alu_control == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (alu_control == OP_SUB)};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:       sc_res = a & b;
      OP_OR:        sc_res = a | b;
      OP_XOR:       sc_res = a ^ b;
      OP_SLTU:      sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:       sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:       sc_res = a << b[SHW-1:0];
      OP_SRL:       sc_res = a >> b[SHW-1:0];
      OP_SRA:       sc_res = $signed(a) >>> b[SHW-1:0];
      4'b1110,
      4'b1111:      sc_ill = 1'b1;
      default:      sc_res = '0;
    endcase
  end

  // One iteration step; acc holds {high/remainder, low/quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   it_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    div_ge    = ~div_diff[WIDTH];
    if ((op_code == OP_MUL) || (op_code == OP_MULHU))
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else
      acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    if ((op_code == OP_MULHU) || (op_code == OP_REMU))
      it_res = acc_nxt[2*WIDTH-1:WIDTH];
    else
      it_res = acc_nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      op_b     <= '0;
      op_code  <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      op_code <= alu_control;
      op_b    <= b;
      if (iter_op) begin
        acc <= {{WIDTH{1'b0}}, a};
        cnt <= SHW'(WIDTH - 1);
      end else begin
        result   <= sc_res;
        zero     <= (sc_res == '0);
        carry    <= sc_carry;
        overflow <= sc_ovf;
        illegal  <= sc_ill;
      end
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt - SHW'(1);
      if (last_iter) begin
        result   <= it_res;
        zero     <= (it_res == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   alu_control;
  logic         zero, carry, overflow, illegal;
  logic [1:0]   state_dbg;

  logic [W+3:0] exp_q[$];
  int           lat_q[$];
  int           checks, errors;
  int           rdy_mode;
  int           neg_cnt, acc_neg;
  logic         prev_valid;
  logic [W+3:0] hold;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: returns {illegal, overflow, carry, zero, result}.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0]   r;
    logic           c, v, il;
    logic [2*W-1:0] p;
    longint         sx, sy, s, lim_hi, lim_lo;
    int             sh;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    lim_hi = (longint'(1) <<< (W - 1)) - 1;
    lim_lo = -(longint'(1) <<< (W - 1));
    sh = int'(y % W);
    p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (op)
      4'd0:  begin {c, r} = {1'b0, x} + {1'b0, y}; s = sx + sy; v = (s > lim_hi) || (s < lim_lo); end
      4'd1:  begin r = x - y; c = (x >= y); s = sx - sy; v = (s > lim_hi) || (s < lim_lo); end
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = (x < y) ? 1 : 0;
      4'd5:  r = x ^ y;
      4'd6:  r = x << sh;
      4'd7:  r = x >> sh;
      4'd8:  r = $signed(x) >>> sh;
      4'd9:  r = (sx < sy) ? 1 : 0;
      4'd10: r = p[W-1:0];
      4'd11: r = p[2*W-1:W];
      4'd12: r = (y == 0) ? '1 : x / y;
      4'd13: r = (y == 0) ? x : x % y;
      default: il = 1'b1;
    endcase
    return {il, v, c, (r == '0), r};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_control = op; a = x; b = y;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    check("accept", {{(W+3){1'b0}}, in_ready}, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, x, y));
    lat_q.push_back(((op >= 4'd10) && (op <= 4'd13)) ? W + 1 : 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 1;
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_neg = neg_cnt;
      if (out_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() != 0) check("latency", neg_cnt - acc_neg, lat_q.pop_front());
          hold = {illegal, overflow, carry, zero, result};
        end else begin
          check("stable", {illegal, overflow, carry, zero, result}, hold);
          check("in_ready_done", {{(W+3){1'b0}}, in_ready}, 0);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else check("result", {illegal, overflow, carry, zero, result}, exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
    neg_cnt++;
  end

  initial begin
    int t;
    checks = 0; errors = 0; rdy_mode = 0; neg_cnt = 0; acc_neg = 0;
    prev_valid = 1'b0; hold = '0;
    in_valid = 1'b0; a = '0; b = '0; alu_control = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {{(W+3){1'b0}}, in_ready}, 1);
    check("rst_out_valid", {{(W+3){1'b0}}, out_valid}, 0);
    check("rst_outputs", {illegal, overflow, carry, zero, result}, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    issue(4'd0, 10, 5);
    issue(4'd1, 10, 10);
    issue(4'd0, 32'h7FFF_FFFF, 1);
    issue(4'd9, 32'hFFFF_FFFF, 1);
    issue(4'd4, 32'hFFFF_FFFF, 1);
    issue(4'd8, 32'h8000_0000, 32'h24);
    issue(4'd6, 1, 31);
    issue(4'd10, 32'hFFFF_FFFF, 2);
    issue(4'd11, 32'hFFFF_FFFF, 2);
    issue(4'd12, 100, 7);
    issue(4'd13, 100, 7);
    issue(4'd12, 5, 0);
    issue(4'd13, 5, 0);
    issue(4'd15, 32'h1234, 32'h5678);
    drain();

    // backpressure with a competing offer that must be ignored
    rdy_mode = 2;
    issue(4'd10, 32'h0001_2345, 32'h0000_0777);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_valid", {{(W+3){1'b0}}, out_valid}, 1);
    in_valid = 1'b1; alu_control = 4'd0; a = 1; b = 1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // reset in the middle of a divide
    issue(4'd12, 100, 7);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {{(W+3){1'b0}}, out_valid}, 0);
    check("abort_in_ready", {{(W+3){1'b0}}, in_ready}, 1);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk); #2 rst_n = 1'b1;
    issue(4'd0, 32'h0000_00FF, 32'h0000_0001);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) issue(4'($urandom_range(0, 15)), pick(), pick());
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
